rect_pixel_generator: RTL and testbench

Parametrised successor to the single-colour background generator. It produces a registered per-pixel colour for the VGA scan-out path from the pixel coordinate. The output is a programmable background plus up to `NUM_RECTS` solid rectangles in fixed priority order. Commands arrive over the existing 32-bit instruction bus, now with a valid/ready handshake and a command FIFO. Rectangle and background updates can be held until vertical blanking, so frames do not tear.

---
 rtl/pixel_gen_pkg.sv | 55 +++++
 rtl/cmd_fifo.sv | 49 ++++
 rtl/rect_pixel_generator.sv | 176 +++++++++++++++++
 tb/tb_rect_pixel_generator.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_gen_pkg.sv
// Shared definitions for the rectangle pixel generator: opcodes, argument
// field positions, the rectangle record and the background preset colours.
package pixel_gen_pkg;

  // Command opcodes (instruction bits [7:0]).
  localparam logic [7:0] OpSetBgColor   = 8'h01;
  localparam logic [7:0] OpBgRed        = 8'h02;
  localparam logic [7:0] OpBgGreen      = 8'h03;
  localparam logic [7:0] OpBgBlue       = 8'h04;
  localparam logic [7:0] OpBgBlack      = 8'h05;
  localparam logic [7:0] OpBgWhite      = 8'h06;
  localparam logic [7:0] OpSetRectPos   = 8'h10;
  localparam logic [7:0] OpSetRectSize  = 8'h11;
  localparam logic [7:0] OpSetRectColor = 8'h12;
  localparam logic [7:0] OpSetRectEn    = 8'h13;
  localparam logic [7:0] OpClearAll     = 8'h20;

  // Argument field positions within instruction bits [31:8].
  localparam int unsigned ArgALsb   = 0;
  localparam int unsigned ArgBLsb   = 10;
  localparam int unsigned ArgFieldW = 10;
  localparam int unsigned ArgIdxLsb = 20;
  localparam int unsigned ArgIdxW   = 4;

  // Widest colour the generator supports; records store colour at this width.
  localparam int unsigned MaxColorW = 20;

  typedef struct packed {
    logic [ArgFieldW-1:0] x;
    logic [ArgFieldW-1:0] y;
    logic [ArgFieldW-1:0] w;
    logic [ArgFieldW-1:0] h;
    logic [MaxColorW-1:0] color;
    logic                 en;
  } rect_t;

  // Preset background colours, packed RGB with three equal fields of color_w/3 bits.
  function automatic logic [MaxColorW-1:0] preset_color(input logic [7:0] op,
                                                        input int unsigned color_w);
    int unsigned          fw;
    logic [MaxColorW-1:0] field;
    logic [MaxColorW-1:0] result;
    fw    = color_w / 3;
    field = (MaxColorW'(1) << fw) - MaxColorW'(1);
    case (op)
      OpBgRed:   result = field << (2 * fw);
      OpBgGreen: result = field << fw;
      OpBgBlue:  result = field;
      OpBgWhite: result = (field << (2 * fw)) | (field << fw) | field;
      default:   result = '0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Small command FIFO with show-ahead read: dout is the head entry whenever !empty.
module cmd_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [Width-1:0] din,
  input  logic             pop,
  output logic [Width-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [PtrW:0]    wr_ptr_q;
  logic [PtrW:0]    rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                   (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Head entry straight off the storage flops.
  assign dout    = mem_q[rd_ptr_q[PtrW-1:0]];

  // Pointer update and storage write; storage itself needs no reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[PtrW-1:0]] <= din;
        wr_ptr_q                  <= wr_ptr_q + (PtrW + 1)'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + (PtrW + 1)'(1);
      end
    end
  end

endmodule

// File: rtl/rect_pixel_generator.sv
// Background plus prioritised solid rectangles, driven by a queued command bus.
// Two-stage pixel pipeline: registered hit vector/colour snapshot, then registered colour.
module rect_pixel_generator
  import pixel_gen_pkg::*;
#(
  parameter int unsigned COLOR_W      = 12,
  parameter int unsigned COORD_W      = 10,
  parameter int unsigned NUM_RECTS    = 4,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned VBLANK_APPLY = 1
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [COORD_W-1:0] i_pixel_x,
  input  logic [COORD_W-1:0] i_pixel_y,
  input  logic               i_vblank,
  input  logic [31:0]        i_instruction,
  input  logic               i_instruction_valid,
  output logic               o_instruction_ready,
  output logic [COLOR_W-1:0] o_color
);

  // Hit sums need one bit above the wider of the pixel and argument fields, so nothing wraps.
  localparam int unsigned CalcW = ((COORD_W > ArgFieldW) ? COORD_W : ArgFieldW) + 1;
  localparam logic [COLOR_W-1:0] BgReset = COLOR_W'(preset_color(OpBgRed, COLOR_W));

  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push;
  logic                 pop;
  logic [31:0]          cmd;
  logic [7:0]           cmd_op;
  logic [23:0]          cmd_args;
  logic [ArgIdxW-1:0]   cmd_idx;
  logic [ArgFieldW-1:0] cmd_a;
  logic [ArgFieldW-1:0] cmd_b;
  logic [COLOR_W-1:0]   cmd_color;

  logic [COLOR_W-1:0]   bg_q;
  rect_t                rects_q [NUM_RECTS];

  logic [CalcW-1:0]     px_ext;
  logic [CalcW-1:0]     py_ext;
  logic [NUM_RECTS-1:0] hit_d;
  logic [NUM_RECTS-1:0] hit_q;
  logic [COLOR_W-1:0]   rect_color_q [NUM_RECTS];
  logic [COLOR_W-1:0]   bg_snap_q;
  logic [COLOR_W-1:0]   color_d;
  logic                 unused_color;

  assign push                = i_instruction_valid && !fifo_full;
  assign pop                 = !fifo_empty && ((VBLANK_APPLY == 0) || i_vblank);
  assign o_instruction_ready = !fifo_full;

  cmd_fifo #(
    .Width(32),
    .Depth(FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk  (i_clk),
    .reset(i_reset),
    .push (push),
    .din  (i_instruction),
    .pop  (pop),
    .dout (cmd),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign cmd_op    = cmd[7:0];
  assign cmd_args  = cmd[31:8];
  assign cmd_idx   = cmd_args[ArgIdxLsb +: ArgIdxW];
  assign cmd_a     = cmd_args[ArgALsb +: ArgFieldW];
  assign cmd_b     = cmd_args[ArgBLsb +: ArgFieldW];
  assign cmd_color = cmd_args[COLOR_W-1:0];

  // Execute the head command on pop; unknown opcodes and out-of-range idx fall through untouched.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      bg_q <= BgReset;
      for (int i = 0; i < NUM_RECTS; i++) begin
        rects_q[i] <= '0;
      end
    end else if (pop) begin
      case (cmd_op)
        OpSetBgColor: bg_q <= cmd_color;
        OpBgRed, OpBgGreen, OpBgBlue, OpBgBlack, OpBgWhite: begin
          bg_q <= COLOR_W'(preset_color(cmd_op, COLOR_W));
        end
        OpClearAll: begin
          bg_q <= BgReset;
          for (int i = 0; i < NUM_RECTS; i++) begin
            rects_q[i].en <= 1'b0;
          end
        end
        default: ;
      endcase
      for (int i = 0; i < NUM_RECTS; i++) begin
        if (cmd_idx == ArgIdxW'(i)) begin
          case (cmd_op)
            OpSetRectPos: begin
              rects_q[i].x <= cmd_a;
              rects_q[i].y <= cmd_b;
            end
            OpSetRectSize: begin
              rects_q[i].w <= cmd_a;
              rects_q[i].h <= cmd_b;
            end
            OpSetRectColor: rects_q[i].color <= MaxColorW'(cmd_color);
            OpSetRectEn:    rects_q[i].en    <= cmd_args[0];
            default: ;
          endcase
        end
      end
    end
  end

  assign px_ext = CalcW'(i_pixel_x);
  assign py_ext = CalcW'(i_pixel_y);

  // Per-rectangle hit test on half-open ranges; zero width or height never hits.
  always_comb begin
    hit_d = '0;
    for (int i = 0; i < NUM_RECTS; i++) begin
      hit_d[i] = rects_q[i].en
          && (px_ext >= CalcW'(rects_q[i].x))
          && (px_ext <  CalcW'(rects_q[i].x) + CalcW'(rects_q[i].w))
          && (py_ext >= CalcW'(rects_q[i].y))
          && (py_ext <  CalcW'(rects_q[i].y) + CalcW'(rects_q[i].h));
    end
  end

  // Stage 1: hit vector plus a colour snapshot taken alongside it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      hit_q     <= '0;
      bg_snap_q <= '0;
      for (int i = 0; i < NUM_RECTS; i++) begin
        rect_color_q[i] <= '0;
      end
    end else begin
      hit_q     <= hit_d;
      bg_snap_q <= bg_q;
      for (int i = 0; i < NUM_RECTS; i++) begin
        rect_color_q[i] <= rects_q[i].color[COLOR_W-1:0];
      end
    end
  end

  // Lowest-index hit wins: walk from highest to lowest so the last assignment dominates.
  always_comb begin
    color_d = bg_snap_q;
    for (int i = int'(NUM_RECTS) - 1; i >= 0; i--) begin
      if (hit_q[i]) begin
        color_d = rect_color_q[i];
      end
    end
  end

  // Stage 2: registered output colour.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_color <= '0;
    end else begin
      o_color <= color_d;
    end
  end

  // Colour records are stored at the maximum width; bits above COLOR_W are never consumed.
  always_comb begin
    unused_color = 1'b0;
    for (int i = 0; i < NUM_RECTS; i++) begin
      unused_color = unused_color ^ (^rects_q[i].color);
    end
  end

endmodule

// File: tb/tb_rect_pixel_generator.sv
// Directed bench: one immediate-mode instance and one vblank-gated instance share clock,
// reset and pixel coordinates; all inputs are driven on the falling edge.
module tb_rect_pixel_generator;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  px;
  logic [9:0]  py;
  logic        vblank;
  logic [31:0] im_instr;
  logic [31:0] vb_instr;
  logic        im_valid;
  logic        vb_valid;
  logic        im_ready;
  logic        vb_ready;
  logic [11:0] im_color;
  logic [11:0] vb_color;
  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  always #5 clk = ~clk;

  rect_pixel_generator #(
    .COLOR_W(12), .COORD_W(10), .NUM_RECTS(4), .FIFO_DEPTH(4), .VBLANK_APPLY(0)
  ) dut_imm (
    .i_clk(clk), .i_reset(rst), .i_pixel_x(px), .i_pixel_y(py), .i_vblank(vblank),
    .i_instruction(im_instr), .i_instruction_valid(im_valid),
    .o_instruction_ready(im_ready), .o_color(im_color)
  );

  rect_pixel_generator #(
    .COLOR_W(12), .COORD_W(10), .NUM_RECTS(4), .FIFO_DEPTH(4), .VBLANK_APPLY(1)
  ) dut_vb (
    .i_clk(clk), .i_reset(rst), .i_pixel_x(px), .i_pixel_y(py), .i_vblank(vblank),
    .i_instruction(vb_instr), .i_instruction_valid(vb_valid),
    .o_instruction_ready(vb_ready), .o_color(vb_color)
  );

  function automatic logic [31:0] mk_xy(input logic [7:0] op, input logic [3:0] idx,
                                        input logic [9:0] a, input logic [9:0] b);
    return {idx, b, a, op};
  endfunction

  function automatic logic [31:0] mk_col(input logic [7:0] op, input logic [3:0] idx,
                                         input logic [11:0] c);
    return {idx, 8'h00, c, op};
  endfunction

  function automatic logic [31:0] mk_en(input logic [3:0] idx, input logic en);
    return {idx, 19'h0, en, 8'h13};
  endfunction

  task automatic chk_im(input string tag, input logic [11:0] exp);
    n_checks++;
    assert (im_color === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%03h, expected 0x%03h", tag, im_color, exp);
    end
  endtask

  task automatic chk_vb(input string tag, input logic [11:0] exp);
    n_checks++;
    assert (vb_color === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%03h, expected 0x%03h", tag, vb_color, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Offer one instruction, wait (bounded) for ready, hold across the accepting edge.
  task automatic send(input bit to_vb, input logic [31:0] ins);
    int guard;
    guard = 0;
    if (to_vb) begin
      vb_instr = ins;
      vb_valid = 1'b1;
    end else begin
      im_instr = ins;
      im_valid = 1'b1;
    end
    while (!(to_vb ? vb_ready : im_ready) && guard < 16) begin
      @(negedge clk);
      guard++;
    end
    if (guard == 16) chk_bit("send_ready", to_vb ? vb_ready : im_ready, 1'b1);
    @(negedge clk);
    vb_valid = 1'b0;
    im_valid = 1'b0;
  endtask

  // Set a pixel and wait long enough for any just-accepted command plus the pipeline.
  task automatic pix(input logic [9:0] x, input logic [9:0] y);
    px = x;
    py = y;
    idle(3);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; vblank = 1'b0; px = '0; py = '0;
    im_instr = '0; vb_instr = '0; im_valid = 1'b0; vb_valid = 1'b0;

    // Reset: two cycles held, then the two-cycle pipeline flush to red.
    idle(2);
    chk_im("rst_color_imm", 12'h000);
    chk_vb("rst_color_vb", 12'h000);
    chk_bit("rst_ready_imm", im_ready, 1'b1);
    chk_bit("rst_ready_vb", vb_ready, 1'b1);
    rst = 1'b0;
    idle(1);
    chk_im("post_rst_c1", 12'h000);
    idle(1);
    chk_im("post_rst_c2_imm", 12'hF00);
    chk_vb("post_rst_c2_vb", 12'hF00);
    pix(10'd1023, 10'd1023);
    chk_im("sweep_corner", 12'hF00);
    pix(10'd512, 10'd300);
    chk_vb("sweep_mid", 12'hF00);

    // Immediate mode: rect0 at (100,50) size 20x10, green.
    send(1'b0, mk_xy(8'h10, 4'd0, 10'd100, 10'd50));
    send(1'b0, mk_xy(8'h11, 4'd0, 10'd20, 10'd10));
    send(1'b0, mk_col(8'h12, 4'd0, 12'h0F0));
    pix(10'd100, 10'd50);
    chk_im("pre_enable", 12'hF00);
    // Enable accepted at edge N: visible in o_color only after edge N+3.
    im_instr = mk_en(4'd0, 1'b1);
    im_valid = 1'b1;
    idle(1);
    im_valid = 1'b0;
    chk_im("en_lat_n", 12'hF00);
    idle(1);
    chk_im("en_lat_n1", 12'hF00);
    idle(1);
    chk_im("en_lat_n2", 12'hF00);
    idle(1);
    chk_im("en_lat_n3", 12'h0F0);
    // Pixel latency: a new coordinate takes two edges to reach o_color.
    px = 10'd120; py = 10'd59;
    idle(1);
    chk_im("pix_lat_1", 12'h0F0);
    idle(1);
    chk_im("pix_lat_2", 12'hF00);
    pix(10'd119, 10'd59);
    chk_im("rect_br_inside", 12'h0F0);
    pix(10'd99, 10'd50);
    chk_im("rect_left_out", 12'hF00);
    pix(10'd100, 10'd60);
    chk_im("rect_below_out", 12'hF00);

    // Priority and clipping: rect0 (1010,50) 20x10 blue, rect1 (1020,40) 10x30 white.
    send(1'b0, mk_xy(8'h10, 4'd0, 10'd1010, 10'd50));
    send(1'b0, mk_col(8'h12, 4'd0, 12'h00F));
    send(1'b0, mk_xy(8'h10, 4'd1, 10'd1020, 10'd40));
    send(1'b0, mk_xy(8'h11, 4'd1, 10'd10, 10'd30));
    send(1'b0, mk_col(8'h12, 4'd1, 12'hFFF));
    send(1'b0, mk_en(4'd1, 1'b1));
    pix(10'd1021, 10'd55);
    chk_im("overlap_rect0_wins", 12'h00F);
    pix(10'd1015, 10'd55);
    chk_im("rect0_only", 12'h00F);
    pix(10'd1023, 10'd65);
    chk_im("rect1_clip_edge", 12'hFFF);
    pix(10'd1019, 10'd65);
    chk_im("left_of_rect1", 12'hF00);
    pix(10'd0, 10'd65);
    chk_im("no_wrap_x0", 12'hF00);
    pix(10'd5, 10'd65);
    chk_im("no_wrap_x5", 12'hF00);
    pix(10'd3, 10'd55);
    chk_im("no_wrap_rect0", 12'hF00);

    // Discards: unknown opcode and idx 9 must leave everything alone.
    send(1'b0, 32'h0000_AA7F);
    send(1'b0, mk_col(8'h12, 4'd9, 12'h0AA));
    send(1'b0, mk_en(4'd9, 1'b0));
    pix(10'd1023, 10'd65);
    chk_im("discard_rect1", 12'hFFF);
    pix(10'd0, 10'd65);
    chk_im("discard_bg", 12'hF00);

    // Presets and clear.
    send(1'b0, 32'h0000_0004);
    pix(10'd0, 10'd65);
    chk_im("preset_blue", 12'h00F);
    send(1'b0, 32'h0000_0006);
    pix(10'd0, 10'd65);
    chk_im("preset_white", 12'hFFF);
    send(1'b0, 32'h0000_0020);
    pix(10'd1023, 10'd65);
    chk_im("clear_all", 12'hF00);

    // Vblank gating: queued command must wait for vblank.
    px = 10'd0; py = 10'd0;
    send(1'b1, mk_col(8'h01, 4'd0, 12'h123));
    idle(4);
    chk_vb("vb_held", 12'hF00);
    vblank = 1'b1;
    idle(1);
    chk_vb("vb_pop_edge", 12'hF00);
    idle(1);
    chk_vb("vb_stage1", 12'hF00);
    idle(1);
    chk_vb("vb_applied", 12'h123);
    vblank = 1'b0;

    // Back-pressure: four accepts fill the FIFO, the fifth is held until a pop.
    vb_valid = 1'b1;
    vb_instr = mk_col(8'h01, 4'd0, 12'h111);
    idle(1);
    vb_instr = mk_col(8'h01, 4'd0, 12'h222);
    idle(1);
    vb_instr = mk_col(8'h01, 4'd0, 12'h333);
    idle(1);
    vb_instr = mk_col(8'h01, 4'd0, 12'h444);
    idle(1);
    chk_bit("bp_ready_low", vb_ready, 1'b0);
    vb_instr = mk_col(8'h01, 4'd0, 12'h555);
    idle(1);
    chk_bit("bp_ready_still_low", vb_ready, 1'b0);
    chk_vb("bp_no_apply", 12'h123);
    vblank = 1'b1;
    idle(1);
    chk_bit("bp_ready_recover", vb_ready, 1'b1);
    idle(1);
    vb_valid = 1'b0;
    idle(1);
    chk_vb("bp_order_1", 12'h111);
    idle(1);
    chk_vb("bp_order_2", 12'h222);
    idle(1);
    chk_vb("bp_order_3", 12'h333);
    idle(1);
    chk_vb("bp_order_4", 12'h444);
    idle(1);
    chk_vb("bp_order_5", 12'h555);
    idle(1);
    chk_vb("bp_order_end", 12'h555);
    vblank = 1'b0;

    // Reset mid-stream: queued commands are dropped.
    send(1'b1, mk_col(8'h01, 4'd0, 12'h456));
    send(1'b1, mk_col(8'h01, 4'd0, 12'h789));
    send(1'b1, mk_col(8'h01, 4'd0, 12'hABC));
    idle(2);
    chk_vb("mid_queued_held", 12'h555);
    rst = 1'b1;
    idle(2);
    chk_vb("mid_rst_color", 12'h000);
    chk_bit("mid_rst_ready", vb_ready, 1'b1);
    rst = 1'b0;
    vblank = 1'b1;
    idle(1);
    chk_vb("mid_post_c1", 12'h000);
    idle(1);
    chk_vb("mid_post_c2", 12'hF00);
    idle(4);
    chk_vb("mid_nothing_applied", 12'hF00);
    vblank = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
